// File: rtl/ahb_mem_slave_ctrl_if.sv
// AHB-Lite bus bundle between the interconnect and one ROM/RAM slave controller.
interface ahb_mem_slave_ctrl_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready_in;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hready_in, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hready_in, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_mem_slave_ctrl.sv
// AHB-Lite slave sequencer for a 4 KB ROM and a 4 KB RAM: decode, wait states,
// byte lanes and the two-cycle ERROR response.
module ahb_mem_slave_ctrl #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE = 32'h0000_1000,
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  ahb_mem_slave_ctrl_if.slave  bus,
  input  logic [31:0]          rom_rdata,
  input  logic [31:0]          ram_rdata,
  output logic                 rom_rd_en,
  output logic [11:0]          rom_addr,
  output logic                 ram_rd_en,
  output logic                 ram_wr_en,
  output logic [11:0]          ram_addr,
  output logic [31:0]          ram_wdata,
  output logic [3:0]           ram_be
);

  localparam logic [2:0] ROM_WAIT_C = 3'(ROM_WAIT);
  localparam logic [2:0] RAM_WAIT_C = 3'(RAM_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] addr_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        rom_q;

  logic        open_phase;
  logic        accept;
  logic        rom_hit;
  logic        ram_hit;
  logic        misalign;
  logic        dec_err;
  logic [2:0]  wait_ld;
  logic [3:0]  be_lanes;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    lane_mask = 4'b0001 << a;
      2'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Address-phase decode; regions are 4 KB aligned so the upper bits identify them.
  assign rom_hit = (bus.haddr[31:12] == ROM_BASE[31:12]);
  assign ram_hit = (bus.haddr[31:12] == RAM_BASE[31:12]);

  always_comb begin
    case (bus.hsize)
      3'd1:    misalign = bus.haddr[0];
      3'd2:    misalign = |bus.haddr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign dec_err = (bus.hsize > 3'd2) | misalign | ~(rom_hit | ram_hit)
                 | (bus.hwrite & rom_hit);
  assign wait_ld = rom_hit ? ROM_WAIT_C : RAM_WAIT_C;

  assign open_phase = (state == S_IDLE) | (state == S_ACCESS) | (state == S_ERR2);
  assign accept     = open_phase & bus.hsel & bus.htrans[1] & bus.hready_in;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) state_nxt = S_ACCESS;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
    if (accept) begin
      if (dec_err) begin
        state_nxt    = S_ERR1;
        wait_cnt_nxt = 3'd0;
      end else if (wait_ld != 3'd0) begin
        state_nxt    = S_WAIT;
        wait_cnt_nxt = wait_ld;
      end else begin
        state_nxt    = S_ACCESS;
        wait_cnt_nxt = 3'd0;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      rom_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q  <= bus.haddr;
        write_q <= bus.hwrite;
        size_q  <= bus.hsize[1:0];
        rom_q   <= rom_hit;
      end
    end
  end

  // Offsets wrap within 4 KB, so only the low 12 bits of the base matter here.
  assign rom_addr = addr_q[11:0] - ROM_BASE[11:0];
  assign ram_addr = addr_q[11:0] - RAM_BASE[11:0];
  assign be_lanes = lane_mask(size_q, addr_q[1:0]);

  always_comb begin
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = 32'd0;
    rom_rd_en     = 1'b0;
    ram_rd_en     = 1'b0;
    ram_wr_en     = 1'b0;
    ram_wdata     = 32'd0;
    ram_be        = 4'd0;
    case (state)
      S_WAIT: begin
        bus.hreadyout = 1'b0;
        rom_rd_en     = ~write_q & rom_q;
        ram_rd_en     = ~write_q & ~rom_q;
      end
      S_ACCESS: begin
        rom_rd_en = ~write_q & rom_q;
        ram_rd_en = ~write_q & ~rom_q;
        // Writes only ever reach ACCESS for RAM; ROM writes decode as errors.
        if (write_q) begin
          ram_wr_en = 1'b1;
          ram_wdata = bus.hwdata;
          ram_be    = be_lanes;
        end else begin
          bus.hrdata = rom_q ? rom_rdata : ram_rdata;
        end
      end
      S_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
      end
      S_ERR2: begin
        bus.hresp = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
